tpu_commit_table_v: RTL and testbench

Parametrised vector commit table, placed in the scalar unit. It allocates an issue number for each vector command sent to the lanes and collects per-lane commit flags against that number. It retires entries strictly in issue order once every enabled lane has committed. It generalises the fixed 8-entry/16-lane commit record to configurable depth and lane count, and adds in-order retirement, occupancy tracking and error detection.

---
 rtl/tpu_commit_table_v.sv | 130 +++++++++++++
 tb/tb_tpu_commit_table_v.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_commit_table_v.sv
// Vector commit table: grants in-order issue numbers, collects per-lane commits, retires in order.
// Optional synchronous flush port enabled by defining TPU_COMMIT_FLUSH_EN.
module tpu_commit_table_v #(
  parameter int NUM_ENTRY = 8,
  parameter int NUM_LANES = 16,
  parameter int WIDTH_NO  = $clog2(NUM_ENTRY)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          I_Issue,
  input  logic [NUM_LANES-1:0]          I_En_Lane,
  output logic                          O_Issue_Ready,
  output logic [WIDTH_NO-1:0]           O_Issue_No,
  input  logic [NUM_LANES-1:0]          I_Commit,
  input  logic [NUM_LANES*WIDTH_NO-1:0] I_Commit_No,
  output logic                          O_Retire,
  output logic [WIDTH_NO-1:0]           O_Retire_No,
  output logic [WIDTH_NO:0]             O_Count,
  output logic                          O_Full,
  output logic                          O_Empty,
`ifdef TPU_COMMIT_FLUSH_EN
  input  logic                          I_Flush,
`endif
  output logic                          O_Err
);

  localparam logic [WIDTH_NO:0]   FULL_CNT = (WIDTH_NO+1)'(NUM_ENTRY);
  localparam logic [WIDTH_NO-1:0] ONE_NO   = WIDTH_NO'(1);

  logic [NUM_ENTRY-1:0] v_q, v_d;
  logic [NUM_LANES-1:0] en_lane_q [NUM_ENTRY];
  logic [NUM_LANES-1:0] en_lane_d [NUM_ENTRY];
  logic [NUM_LANES-1:0] en_commit_q [NUM_ENTRY];
  logic [NUM_LANES-1:0] en_commit_d [NUM_ENTRY];
  logic [WIDTH_NO-1:0]  wp_q, wp_d, rp_q, rp_d;
  logic [WIDTH_NO:0]    count_q, count_d;
  logic                 retire_q, retire_d;
  logic [WIDTH_NO-1:0]  retire_no_q, retire_no_d;
  logic                 err_q, err_d;
  logic                 full, issue_ok, done;
  logic [WIDTH_NO-1:0]  cno;

  assign full          = (count_q == FULL_CNT);
  assign O_Full        = full;
  assign O_Empty       = (count_q == '0);
  assign O_Issue_Ready = !full;
  assign O_Issue_No    = wp_q;
  assign O_Count       = count_q;
  assign O_Retire      = retire_q;
  assign O_Retire_No   = retire_no_q;
  assign O_Err         = err_q;

  assign issue_ok = I_Issue && !full;
  assign done     = v_q[rp_q] && ((en_commit_q[rp_q] & en_lane_q[rp_q]) == en_lane_q[rp_q]);

  always_comb begin
    v_d         = v_q;
    en_lane_d   = en_lane_q;
    en_commit_d = en_commit_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    retire_d    = 1'b0;
    retire_no_d = retire_no_q;
    err_d       = err_q;
    cno         = '0;

    if (I_Issue && full) err_d = 1'b1;

    // Commit legality is judged on pre-edge state, so a commit racing its own issue is an error.
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      cno = I_Commit_No[l*WIDTH_NO +: WIDTH_NO];
      if (I_Commit[l]) begin
        if (v_q[cno] && en_lane_q[cno][l] && !en_commit_q[cno][l]) en_commit_d[cno][l] = 1'b1;
        else err_d = 1'b1;
      end
    end

    if (done) begin
      v_d[rp_q]   = 1'b0;
      retire_d    = 1'b1;
      retire_no_d = rp_q;
      rp_d        = rp_q + ONE_NO;
    end

    if (issue_ok) begin
      v_d[wp_q]         = 1'b1;
      en_lane_d[wp_q]   = I_En_Lane;
      en_commit_d[wp_q] = '0;
      wp_d              = wp_q + ONE_NO;
    end

    count_d = count_q + (WIDTH_NO+1)'(issue_ok) - (WIDTH_NO+1)'(done);

`ifdef TPU_COMMIT_FLUSH_EN
    if (I_Flush) begin
      v_d      = '0;
      wp_d     = '0;
      rp_d     = '0;
      count_d  = '0;
      err_d    = 1'b0;
      retire_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      v_q         <= '0;
      en_lane_q   <= '{default: '0};
      en_commit_q <= '{default: '0};
      wp_q        <= '0;
      rp_q        <= '0;
      count_q     <= '0;
      retire_q    <= 1'b0;
      retire_no_q <= '0;
      err_q       <= 1'b0;
    end else begin
      v_q         <= v_d;
      en_lane_q   <= en_lane_d;
      en_commit_q <= en_commit_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      count_q     <= count_d;
      retire_q    <= retire_d;
      retire_no_q <= retire_no_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_tpu_commit_table_v.sv
// Scoreboard bench for tpu_commit_table_v: queue-based reference model, decoupled retire monitor.
module tb_tpu_commit_table_v;
  localparam int N = 8;
  localparam int L = 16;
  localparam int W = 3;

  logic           clock = 1'b0;
  logic           reset;
  logic           I_Issue;
  logic [L-1:0]   I_En_Lane;
  logic           O_Issue_Ready;
  logic [W-1:0]   O_Issue_No;
  logic [L-1:0]   I_Commit;
  logic [L*W-1:0] I_Commit_No;
  logic           O_Retire;
  logic [W-1:0]   O_Retire_No;
  logic [W:0]     O_Count;
  logic           O_Full, O_Empty, O_Err;
`ifdef TPU_COMMIT_FLUSH_EN
  logic           I_Flush = 1'b0;
`endif

  tpu_commit_table_v #(.NUM_ENTRY(N), .NUM_LANES(L), .WIDTH_NO(W)) dut (
    .clock(clock), .reset(reset), .I_Issue(I_Issue), .I_En_Lane(I_En_Lane),
    .O_Issue_Ready(O_Issue_Ready), .O_Issue_No(O_Issue_No), .I_Commit(I_Commit),
    .I_Commit_No(I_Commit_No), .O_Retire(O_Retire), .O_Retire_No(O_Retire_No),
    .O_Count(O_Count), .O_Full(O_Full), .O_Empty(O_Empty),
`ifdef TPU_COMMIT_FLUSH_EN
    .I_Flush(I_Flush),
`endif
    .O_Err(O_Err));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: pending issue numbers in order, plus per-number lane masks.
  int           pend[$];
  logic [L-1:0] mlanes[N];
  logic [L-1:0] mcom[N];
  int           mwp  = 0;
  bit           merr = 0;

  typedef struct { int no; int cyc; } exp_t;
  exp_t sb[$];

  function automatic bit in_pend(input int e);
    foreach (pend[i]) if (pend[i] == e) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step(input bit rst, input bit iss, input logic [L-1:0] en,
                      input logic [L-1:0] com, input logic [L*W-1:0] cnos, input bit fl);
    logic [L-1:0] ncom[N];
    bit full_pre;
    int e, head;
    chk("count", O_Count, pend.size());
    chk("full", O_Full, pend.size() == N);
    chk("empty", O_Empty, pend.size() == 0);
    chk("issue_ready", O_Issue_Ready, pend.size() != N);
    chk("issue_no", O_Issue_No, mwp);
    chk("err", O_Err, merr);
    reset = rst; I_Issue = iss; I_En_Lane = en; I_Commit = com; I_Commit_No = cnos;
`ifdef TPU_COMMIT_FLUSH_EN
    I_Flush = fl;
`endif
    if (rst || fl) begin
      pend.delete();
      mwp  = 0;
      merr = 0;
    end else begin
      ncom     = mcom;
      full_pre = (pend.size() == N);
      for (int l = 0; l < L; l++) begin
        if (com[l]) begin
          e = int'(cnos[l*W +: W]);
          if (in_pend(e) && mlanes[e][l] && !mcom[e][l]) ncom[e][l] = 1'b1;
          else merr = 1'b1;
        end
      end
      if (pend.size() > 0) begin
        head = pend[0];
        if ((mcom[head] & mlanes[head]) == mlanes[head]) begin
          sb.push_back('{head, cyc + 1});
          void'(pend.pop_front());
        end
      end
      if (iss) begin
        if (full_pre) merr = 1'b1;
        else begin
          pend.push_back(mwp);
          mlanes[mwp] = en;
          ncom[mwp]   = '0;
          mwp         = (mwp + 1) % N;
        end
      end
      mcom = ncom;
    end
    @(negedge clock);
    if (rst) chk("retire_no_after_reset", O_Retire_No, 0);
  endtask

  function automatic logic [L*W-1:0] all_no(input int n);
    logic [L*W-1:0] v;
    for (int l = 0; l < L; l++) v[l*W +: W] = W'(n);
    return v;
  endfunction

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, '0, '0, '0, 0);
  endtask

  task automatic issue(input logic [L-1:0] en);
    step(0, 1, en, '0, '0, 0);
  endtask

  task automatic rand_step();
    logic [L-1:0]   en, com;
    logic [L*W-1:0] cnos;
    int cand[$];
    bit iss;
    iss  = ($urandom_range(0, 99) < 45);
    case ($urandom_range(0, 9))
      0:       en = '0;
      1, 2:    en = L'($urandom()) & L'($urandom());
      default: en = L'($urandom());
    endcase
    com  = '0;
    cnos = L*W'($urandom());
    for (int l = 0; l < L; l++) begin
      if ($urandom_range(0, 99) < 35) begin
        cand.delete();
        foreach (pend[i]) if (mlanes[pend[i]][l] && !mcom[pend[i]][l]) cand.push_back(pend[i]);
        if ($urandom_range(0, 99) < 3) begin
          com[l] = 1'b1;
        end else if (cand.size() > 0) begin
          com[l] = 1'b1;
          cnos[l*W +: W] = W'(cand[$urandom_range(0, cand.size() - 1)]);
        end
      end
    end
    step(($urandom_range(0, 199) == 0), iss, en, com, cnos, 0);
  endtask

  always @(negedge clock) begin
    if (O_Retire === 1'b1) begin
      if (sb.size() == 0) chk("retire_spurious", O_Retire, 0);
      else begin
        chk("retire_no", O_Retire_No, sb[0].no);
        chk("retire_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
    end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      chk("retire_missing", O_Retire, 1);
      void'(sb.pop_front());
    end
  end

  initial begin
    reset = 1'b1; I_Issue = 1'b0; I_En_Lane = '0; I_Commit = '0; I_Commit_No = '0;
    @(negedge clock);
    chk("reset_retire", O_Retire, 0);
    chk("reset_retire_no", O_Retire_No, 0);

    // Four-lane entry completed in a single commit cycle
    step(1, 0, '0, '0, '0, 0);
    issue(16'h000F);
    step(0, 0, '0, 16'h000F, all_no(0), 0);
    idle(3);

    // Fill to full, reject the ninth, then free slot 0 and wrap
    step(1, 0, '0, '0, '0, 0);
    for (int i = 0; i < N; i++) issue(16'h0001);
    issue(16'h0001);
    step(0, 0, '0, 16'h0001, all_no(0), 0);
    step(0, 1, 16'h0001, '0, '0, 0);
    idle(1);
    issue(16'h0002);
    idle(2);

    // Out-of-order completion retires in order
    step(1, 0, '0, '0, '0, 0);
    for (int i = 0; i < 3; i++) issue('1);
    step(0, 0, '0, '1, all_no(2), 0);
    step(0, 0, '0, '1, all_no(1), 0);
    step(0, 0, '0, '1, all_no(0), 0);
    idle(4);

    // Protocol errors: empty entry, duplicate lane commit
    step(1, 0, '0, '0, '0, 0);
    step(0, 0, '0, 16'h0020, all_no(3), 0);
    step(1, 0, '0, '0, '0, 0);
    issue(16'h0004);
    issue(16'h0000);
    step(0, 0, '0, 16'h0004, all_no(0), 0);
    step(0, 0, '0, 16'h0004, all_no(0), 0);
    idle(3);

    // Lane-less entry retires with no commits; commit racing its own issue
    step(1, 0, '0, '0, '0, 0);
    issue('0);
    idle(3);
    step(0, 1, 16'h0001, 16'h0001, all_no(1), 0);
    idle(2);

`ifdef TPU_COMMIT_FLUSH_EN
    step(1, 0, '0, '0, '0, 0);
    for (int i = 0; i < 4; i++) issue('1);
    step(0, 1, '1, '0, '0, 1);
    idle(3);
`endif

    step(1, 0, '0, '0, '0, 0);
    for (int i = 0; i < 3000; i++) rand_step();
    idle(N + 4);
    chk("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
